readout_tx_multitone_gen: RTL and testbench



---
 rtl/readout_tx_pkg.sv | 19 +
 rtl/readout_tx_multitone_gen_if.sv | 44 ++++
 rtl/readout_tx_tone_ch.sv | 83 ++++++++
 rtl/readout_tx_multitone_gen.sv | 141 ++++++++++++++
 tb/tb_readout_tx_multitone_gen.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/readout_tx_pkg.sv
// Shared types and constants for the multitone readout TX generator.
// FSM encoding, config field selects and the summed-output width helper.
package readout_tx_pkg;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_PLAY = 1'b1
   } tx_state_t;

   localparam logic [1:0] CFG_FTW       = 2'd0;
   localparam logic [1:0] CFG_PHASE_OFF = 2'd1;
   localparam logic [1:0] CFG_AMP       = 2'd2;

   // Enough headroom that summing num_ch full-scale tones can never wrap.
   function automatic int out_width(input int num_ch, input int lut_w);
      return lut_w + $clog2(num_ch);
   endfunction

endpackage

// File: rtl/readout_tx_multitone_gen_if.sv
// Bundle of config, instruction, LUT and waveform signals of the multitone generator.
// master = instruction issue stage / LUT owner side, slave = generator.
interface readout_tx_multitone_gen_if #(
   parameter int NUM_CH             = 4,
   parameter int NCO_N              = 22,
   parameter int PHASE_WIDTH        = 10,
   parameter int SIN_LUT_DATA_WIDTH = 16,
   parameter int DUR_WIDTH          = 12,
   parameter int CH_IDX_WIDTH       = $clog2(NUM_CH),
   parameter int OUT_WIDTH          = SIN_LUT_DATA_WIDTH + $clog2(NUM_CH)
) ();

   logic                                 cfg_wr_en;
   logic [1:0]                           cfg_sel;
   logic [CH_IDX_WIDTH-1:0]              cfg_ch;
   logic [NCO_N-1:0]                     cfg_data;

   logic                                 inst_valid;
   logic                                 inst_ready;
   logic [NUM_CH-1:0]                    inst_ch_mask;
   logic [DUR_WIDTH-1:0]                 inst_duration;

   logic [NUM_CH*PHASE_WIDTH-1:0]        sin_lut_rd_addr_out;
   logic [NUM_CH*SIN_LUT_DATA_WIDTH-1:0] sin_lut_rd_data_in;

   logic                                 valid_wave_out;
   logic [OUT_WIDTH-1:0]                 wave_out;
   logic                                 busy;

   modport master (
      output cfg_wr_en, cfg_sel, cfg_ch, cfg_data,
      output inst_valid, inst_ch_mask, inst_duration,
      output sin_lut_rd_data_in,
      input  inst_ready, sin_lut_rd_addr_out, valid_wave_out, wave_out, busy
   );

   modport slave (
      input  cfg_wr_en, cfg_sel, cfg_ch, cfg_data,
      input  inst_valid, inst_ch_mask, inst_duration,
      input  sin_lut_rd_data_in,
      output inst_ready, sin_lut_rd_addr_out, valid_wave_out, wave_out, busy
   );

endinterface

// File: rtl/readout_tx_tone_ch.sv
// One NCO tone: config registers, free-running accumulator, LUT address register
// and amplitude scaling stage (E1 address, E2 LUT data, E3 scaled product).
module readout_tx_tone_ch
   import readout_tx_pkg::*;
#(
   parameter int NCO_N              = 22,
   parameter int PHASE_WIDTH        = 10,
   parameter int SIN_LUT_DATA_WIDTH = 16,
   parameter int AMP_WIDTH          = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          i_cfg_wr_en,
   input  logic [1:0]                    i_cfg_sel,
   input  logic [NCO_N-1:0]              i_cfg_data,
   input  logic                          i_issue,
   input  logic                          i_mask_e2,
   input  logic [SIN_LUT_DATA_WIDTH-1:0] i_lut_data,
   output logic [PHASE_WIDTH-1:0]        o_addr,
   output logic [SIN_LUT_DATA_WIDTH-1:0] o_prod
);

   localparam int PROD_W = SIN_LUT_DATA_WIDTH + AMP_WIDTH + 1;

   logic [NCO_N-1:0]              r_ftw;
   logic [PHASE_WIDTH-1:0]        r_phase_off;
   logic [AMP_WIDTH-1:0]          r_amp;
   logic [NCO_N-1:0]              r_acc;
   logic [PHASE_WIDTH-1:0]        r_addr;
   logic [SIN_LUT_DATA_WIDTH-1:0] r_lut;
   logic [SIN_LUT_DATA_WIDTH-1:0] r_prod;

   logic [PHASE_WIDTH-1:0]        w_phase;
   logic [PROD_W-1:0]             w_lut_ext;
   logic [PROD_W-1:0]             w_amp_ext;
   logic [PROD_W-1:0]             w_prod_full;
   logic [SIN_LUT_DATA_WIDTH-1:0] w_scaled;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ftw       <= '0;
         r_phase_off <= '0;
         r_amp       <= '0;
      end else if (i_cfg_wr_en) begin
         case (i_cfg_sel)
            CFG_FTW:       r_ftw       <= i_cfg_data;
            CFG_PHASE_OFF: r_phase_off <= i_cfg_data[PHASE_WIDTH-1:0];
            CFG_AMP:       r_amp       <= i_cfg_data[AMP_WIDTH-1:0];
            default:       ;
         endcase
      end
   end

   // Accumulator never stops, so tones stay phase-coherent across pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_acc <= '0;
      else     r_acc <= r_acc + r_ftw;
   end

   assign w_phase = r_acc[NCO_N-1 -: PHASE_WIDTH] + r_phase_off;

   // Two's-complement extension makes the low PROD_W bits of the product exact.
   assign w_lut_ext   = {{(PROD_W-SIN_LUT_DATA_WIDTH){r_lut[SIN_LUT_DATA_WIDTH-1]}}, r_lut};
   assign w_amp_ext   = {{(PROD_W-AMP_WIDTH){1'b0}}, r_amp};
   assign w_prod_full = w_lut_ext * w_amp_ext;
   assign w_scaled    = w_prod_full[AMP_WIDTH +: SIN_LUT_DATA_WIDTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_addr <= '0;
         r_lut  <= '0;
         r_prod <= '0;
      end else begin
         r_addr <= i_issue ? w_phase : '0;
         r_lut  <= i_lut_data;
         r_prod <= i_mask_e2 ? w_scaled : '0;
      end
   end

   assign o_addr = r_addr;
   assign o_prod = r_prod;

endmodule

// File: rtl/readout_tx_multitone_gen.sv
// Multitone readout TX generator: pulse FSM, duration counter, mask/valid pipeline
// and the adder tree summing NUM_CH scaled tones into one sample stream.
module readout_tx_multitone_gen
   import readout_tx_pkg::*;
#(
   parameter int NUM_CH             = 4,
   parameter int NCO_N              = 22,
   parameter int PHASE_WIDTH        = 10,
   parameter int SIN_LUT_DATA_WIDTH = 16,
   parameter int AMP_WIDTH          = 8,
   parameter int DUR_WIDTH          = 12,
   parameter int CH_IDX_WIDTH       = $clog2(NUM_CH),
   parameter int OUT_WIDTH          = out_width(NUM_CH, SIN_LUT_DATA_WIDTH)
) (
   input logic                           clk,
   input logic                           rst,
   readout_tx_multitone_gen_if.slave     bus
);

   // state  | meaning
   // S_IDLE | no pulse issuing, inst_ready held high
   // S_PLAY | one sample issued per cycle while cnt counts down to 1

   localparam int SW = SIN_LUT_DATA_WIDTH;

   tx_state_t            r_state, w_state_nxt;
   logic [DUR_WIDTH-1:0] r_cnt, w_cnt_nxt;
   logic [NUM_CH-1:0]    r_mask, w_mask_nxt;
   logic                 w_ready;
   logic                 w_issue;
   logic                 w_dur_nz;

   logic                 r_v1, r_v2, r_v3, r_valid_out;
   logic [NUM_CH-1:0]    r_m1, r_m2;
   logic [OUT_WIDTH-1:0] r_wave;
   logic [OUT_WIDTH-1:0] w_sum;

   logic [NUM_CH*PHASE_WIDTH-1:0] w_addr_bus;
   logic [NUM_CH*SW-1:0]          w_prod_bus;

   assign w_dur_nz = (bus.inst_duration != '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_mask  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_mask  <= w_mask_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_mask_nxt  = r_mask;
      w_ready     = 1'b0;
      w_issue     = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_ready = 1'b1;
            if (bus.inst_valid && w_dur_nz) begin
               w_cnt_nxt   = bus.inst_duration;
               w_mask_nxt  = bus.inst_ch_mask;
               w_state_nxt = S_PLAY;
            end
         end
         S_PLAY: begin
            w_issue   = 1'b1;
            w_ready   = (r_cnt == DUR_WIDTH'(1));
            w_cnt_nxt = r_cnt - DUR_WIDTH'(1);
            // Last sample of this pulse: hand off gaplessly or fall back to idle.
            if (w_ready) begin
               if (bus.inst_valid && w_dur_nz) begin
                  w_cnt_nxt  = bus.inst_duration;
                  w_mask_nxt = bus.inst_ch_mask;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_v1        <= 1'b0;
         r_v2        <= 1'b0;
         r_v3        <= 1'b0;
         r_valid_out <= 1'b0;
         r_m1        <= '0;
         r_m2        <= '0;
         r_wave      <= '0;
      end else begin
         r_v1        <= w_issue;
         r_v2        <= r_v1;
         r_v3        <= r_v2;
         r_valid_out <= r_v3;
         r_m1        <= w_issue ? r_mask : '0;
         r_m2        <= r_m1;
         r_wave      <= w_sum;
      end
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      readout_tx_tone_ch #(
         .NCO_N              (NCO_N),
         .PHASE_WIDTH        (PHASE_WIDTH),
         .SIN_LUT_DATA_WIDTH (SW),
         .AMP_WIDTH          (AMP_WIDTH)
      ) u_tone (
         .clk         (clk),
         .rst         (rst),
         .i_cfg_wr_en (bus.cfg_wr_en && (bus.cfg_ch == CH_IDX_WIDTH'(c))),
         .i_cfg_sel   (bus.cfg_sel),
         .i_cfg_data  (bus.cfg_data),
         .i_issue     (w_issue && r_mask[c]),
         .i_mask_e2   (r_m2[c]),
         .i_lut_data  (bus.sin_lut_rd_data_in[c*SW +: SW]),
         .o_addr      (w_addr_bus[c*PHASE_WIDTH +: PHASE_WIDTH]),
         .o_prod      (w_prod_bus[c*SW +: SW])
      );
   end

   always_comb begin
      w_sum = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         w_sum = w_sum + {{(OUT_WIDTH-SW){w_prod_bus[c*SW+SW-1]}}, w_prod_bus[c*SW +: SW]};
      end
   end

   assign bus.inst_ready          = w_ready;
   assign bus.sin_lut_rd_addr_out = w_addr_bus;
   assign bus.valid_wave_out      = r_valid_out;
   assign bus.wave_out            = r_wave;
   assign bus.busy                = (r_state == S_PLAY) || r_v1 || r_v2 || r_v3 || r_valid_out;

endmodule

// File: tb/tb_readout_tx_multitone_gen.sv
// Directed bench for readout_tx_multitone_gen with a constant-value LUT model.
module tb_readout_tx_multitone_gen;
   import readout_tx_pkg::*;

   localparam int NUM_CH = 4;
   localparam int NCO_N  = 22;
   localparam int PW     = 10;
   localparam int SW     = 16;
   localparam int AW     = 8;
   localparam int DW     = 12;

   logic clk = 1'b0;
   logic rst;
   logic [SW-1:0] r_lut_val;
   int n_checks = 0;
   int n_fail   = 0;

   readout_tx_multitone_gen_if #(
      .NUM_CH(NUM_CH), .NCO_N(NCO_N), .PHASE_WIDTH(PW),
      .SIN_LUT_DATA_WIDTH(SW), .DUR_WIDTH(DW)
   ) bus ();

   readout_tx_multitone_gen #(
      .NUM_CH(NUM_CH), .NCO_N(NCO_N), .PHASE_WIDTH(PW),
      .SIN_LUT_DATA_WIDTH(SW), .AMP_WIDTH(AW), .DUR_WIDTH(DW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   assign bus.sin_lut_rd_data_in = {NUM_CH{r_lut_val}};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_write(input logic [1:0] sel, input int ch, input int data);
      bus.cfg_wr_en = 1'b1;
      bus.cfg_sel   = sel;
      bus.cfg_ch    = ch[1:0];
      bus.cfg_data  = data[NCO_N-1:0];
      tick();
      bus.cfg_wr_en = 1'b0;
   endtask

   task automatic send_inst(input logic [NUM_CH-1:0] mask, input int dur);
      bus.inst_valid    = 1'b1;
      bus.inst_ch_mask  = mask;
      bus.inst_duration = dur[DW-1:0];
      tick();
      bus.inst_valid    = 1'b0;
   endtask

   task automatic wait_valid(input int max, output int lat);
      int i;
      lat = -1;
      i = 0;
      while (lat < 0 && i < max) begin
         tick();
         i++;
         if (bus.valid_wave_out === 1'b1) lat = i;
      end
   endtask

   task automatic drain();
      int i;
      i = 0;
      while (bus.busy !== 1'b0 && i < 40) begin
         tick();
         i++;
      end
      n_checks++;
      if (bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL drain: busy=%b required 0", bus.busy);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      n_checks++;
      if (bus.wave_out !== '0) begin n_fail++; $display("FAIL reset_wave: got %h required 0", bus.wave_out); end
      n_checks++;
      if (bus.valid_wave_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b required 0", bus.valid_wave_out); end
      n_checks++;
      if (bus.sin_lut_rd_addr_out !== '0) begin n_fail++; $display("FAIL reset_addr: got %h required 0", bus.sin_lut_rd_addr_out); end
      n_checks++;
      if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", bus.busy); end
      n_checks++;
      if (bus.inst_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b required 1", bus.inst_ready); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_single_tone();
      int lat;
      r_lut_val = 16'h1000;
      cfg_write(CFG_AMP, 0, 128);
      send_inst(4'b0001, 5);
      wait_valid(10, lat);
      n_checks++;
      if (lat != 4) begin n_fail++; $display("FAIL single_latency: got %0d required 4", lat); end
      for (int k = 0; k < 5; k++) begin
         if (k > 0) tick();
         n_checks++;
         if (bus.valid_wave_out !== 1'b1 || int'($signed(bus.wave_out)) !== 2048) begin
            n_fail++;
            $display("FAIL single_sample%0d: valid=%b wave=%0d required valid=1 wave=2048",
                     k, bus.valid_wave_out, $signed(bus.wave_out));
         end
         n_checks++;
         if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL single_busy%0d: got %b required 1", k, bus.busy); end
      end
      tick();
      n_checks++;
      if (bus.valid_wave_out !== 1'b0 || bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL single_end: valid=%b busy=%b required 0 0", bus.valid_wave_out, bus.busy);
      end
   endtask

   task automatic test_sum_extremes();
      int lat;
      logic [NUM_CH-1:0] masks [3];
      logic [SW-1:0]     luts  [3];
      int                exps  [3];
      masks = '{4'b1111, 4'b1111, 4'b0101};
      luts  = '{16'h7FFF, 16'h8000, 16'h7FFF};
      exps  = '{130556, -130560, 65278};
      for (int c = 0; c < NUM_CH; c++) cfg_write(CFG_AMP, c, 255);
      for (int t = 0; t < 3; t++) begin
         r_lut_val = luts[t];
         send_inst(masks[t], 2);
         wait_valid(10, lat);
         for (int k = 0; k < 2; k++) begin
            if (k > 0) tick();
            n_checks++;
            if (bus.valid_wave_out !== 1'b1 || int'($signed(bus.wave_out)) !== exps[t]) begin
               n_fail++;
               $display("FAIL sum_case%0d_s%0d: valid=%b wave=%0d required valid=1 wave=%0d",
                        t, k, bus.valid_wave_out, $signed(bus.wave_out), exps[t]);
            end
         end
         drain();
      end
   endtask

   task automatic test_phase_wrap();
      int exp_addr [8];
      exp_addr = '{1021, 1022, 1023, 0, 1005, 1006, 1007, 1008};
      cfg_write(CFG_PHASE_OFF, 0, 1020);
      cfg_write(CFG_FTW, 0, 4096);
      send_inst(4'b0001, 8);
      for (int j = 1; j <= 8; j++) begin
         tick();
         n_checks++;
         if (int'(bus.sin_lut_rd_addr_out[PW-1:0]) !== exp_addr[j-1]) begin
            n_fail++;
            $display("FAIL phase_addr%0d: got %0d required %0d", j, bus.sin_lut_rd_addr_out[PW-1:0], exp_addr[j-1]);
         end
         if (j == 3) begin
            bus.cfg_wr_en = 1'b1;
            bus.cfg_sel   = CFG_PHASE_OFF;
            bus.cfg_ch    = 2'd0;
            bus.cfg_data  = 22'd1000;
         end
         if (j == 4) bus.cfg_wr_en = 1'b0;
      end
      tick();
      n_checks++;
      if (bus.sin_lut_rd_addr_out !== '0) begin
         n_fail++;
         $display("FAIL phase_addr_idle: got %h required 0", bus.sin_lut_rd_addr_out);
      end
      drain();
   endtask

   task automatic test_back_to_back();
      r_lut_val = 16'h1000;
      send_inst(4'b0001, 3);
      tick();
      n_checks++;
      if (bus.inst_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_cnt2: got %b required 0", bus.inst_ready); end
      tick();
      n_checks++;
      if (bus.inst_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_cnt1: got %b required 1", bus.inst_ready); end
      send_inst(4'b0011, 3);
      tick();
      for (int k = 0; k < 6; k++) begin
         if (k > 0) tick();
         n_checks++;
         if (bus.valid_wave_out !== 1'b1 || int'($signed(bus.wave_out)) !== ((k < 3) ? 4080 : 8160)) begin
            n_fail++;
            $display("FAIL b2b_sample%0d: valid=%b wave=%0d required valid=1 wave=%0d",
                     k, bus.valid_wave_out, $signed(bus.wave_out), (k < 3) ? 4080 : 8160);
         end
      end
      tick();
      n_checks++;
      if (bus.valid_wave_out !== 1'b0) begin n_fail++; $display("FAIL b2b_end: valid=%b required 0", bus.valid_wave_out); end
      drain();
   endtask

   task automatic test_zero_duration();
      int seen;
      send_inst(4'b1111, 0);
      n_checks++;
      if (bus.inst_ready !== 1'b1 || bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL zero_idle: ready=%b busy=%b required 1 0", bus.inst_ready, bus.busy);
      end
      seen = 0;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (bus.valid_wave_out !== 1'b0) seen++;
      end
      n_checks++;
      if (seen != 0) begin n_fail++; $display("FAIL zero_no_output: valid cycles=%0d required 0", seen); end
   endtask

   task automatic test_reset_mid();
      int lat;
      r_lut_val = 16'h1000;
      send_inst(4'b0001, 100);
      wait_valid(10, lat);
      for (int k = 1; k < 10; k++) tick();
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if (bus.valid_wave_out !== 1'b0 || bus.wave_out !== '0 || bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_clear: valid=%b wave=%h busy=%b required 0 0 0",
                  bus.valid_wave_out, bus.wave_out, bus.busy);
      end
      tick();
      rst = 1'b0;
      cfg_write(CFG_PHASE_OFF, 0, 5);
      cfg_write(CFG_AMP, 0, 64);
      send_inst(4'b0001, 2);
      tick();
      n_checks++;
      if (int'(bus.sin_lut_rd_addr_out[PW-1:0]) !== 5) begin
         n_fail++;
         $display("FAIL rstmid_addr: got %0d required 5", bus.sin_lut_rd_addr_out[PW-1:0]);
      end
      wait_valid(10, lat);
      n_checks++;
      if (lat != 3) begin n_fail++; $display("FAIL rstmid_latency: got %0d required 3", lat); end
      for (int k = 0; k < 2; k++) begin
         if (k > 0) tick();
         n_checks++;
         if (bus.valid_wave_out !== 1'b1 || int'($signed(bus.wave_out)) !== 1024) begin
            n_fail++;
            $display("FAIL rstmid_sample%0d: valid=%b wave=%0d required valid=1 wave=1024",
                     k, bus.valid_wave_out, $signed(bus.wave_out));
         end
      end
      tick();
      n_checks++;
      if (bus.valid_wave_out !== 1'b0) begin n_fail++; $display("FAIL rstmid_end: valid=%b required 0", bus.valid_wave_out); end
   endtask

   initial begin
      rst               = 1'b1;
      r_lut_val         = '0;
      bus.cfg_wr_en     = 1'b0;
      bus.cfg_sel       = 2'd0;
      bus.cfg_ch        = '0;
      bus.cfg_data      = '0;
      bus.inst_valid    = 1'b0;
      bus.inst_ch_mask  = '0;
      bus.inst_duration = '0;
      test_reset();
      test_single_tone();
      test_sum_extremes();
      test_phase_wrap();
      test_back_to_back();
      test_zero_duration();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached before completion");
      $fatal(1, "watchdog");
   end

endmodule
